// File: rtl/stallable_mult_pipe_pkg.sv
// Sizing helpers and parameter limits shared by the stallable multiplier slice.
package stallable_pkg;

  localparam int unsigned MIN_LATENCY = 2;
  localparam int unsigned MIN_WIDTH   = 1;

  function automatic int unsigned out_width(input int unsigned width,
                                            input int unsigned full_product);
    return (full_product != 0) ? 2 * width : width;
  endfunction

  function automatic int unsigned occ_width(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/stallable_mult_pipe_if.sv
// Operand/result bundle between a stall-driving controller and the multiplier pipe.
interface stallable_mult_pipe_if
  import stallable_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned FULL_PRODUCT = 0
);
  localparam int unsigned OW   = out_width(WIDTH, FULL_PRODUCT);
  localparam int unsigned OCCW = occ_width(LATENCY);

  logic             stall;
  logic             in_valid;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [OW-1:0]    out;
  logic             out_valid;
  logic [OCCW-1:0]  occupancy;
  logic             busy;

  modport master (
    output stall, in_valid, left, right,
    input  out, out_valid, occupancy, busy
  );

  modport slave (
    input  stall, in_valid, left, right,
    output out, out_valid, occupancy, busy
  );

endinterface

// File: rtl/stallable_mult_pipe_delay_line.sv
// Enable-gated data+valid register chain; clr drops valid bits but keeps data.
module stallable_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) data[i] <= '0;
      vld <= '0;
    end else begin
      if (en) begin
        data[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) data[i] <= data[i-1];
      end
      if (clr) begin
        vld <= '0;
      end else if (en) begin
        vld[0] <= d_valid;
        for (int unsigned i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
      end
    end
  end

  assign q       = data[DEPTH-1];
  assign q_valid = vld[DEPTH-1];

endmodule

// File: rtl/stallable_mult_pipe.sv
// Stall-aware pipelined multiplier with per-stage valid bits and occupancy count.
// Define STALLABLE_MULT_FLUSH_EN to add the flush port (valid/occupancy clear).
module stallable_mult_pipe
  import stallable_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned SIGNED       = 0,
  parameter int unsigned FULL_PRODUCT = 0
) (
  input  logic clk,
  input  logic reset_n,
`ifdef STALLABLE_MULT_FLUSH_EN
  input  logic flush,
`endif
  stallable_mult_pipe_if.slave bus
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned OW   = out_width(WIDTH, FULL_PRODUCT);
  localparam int unsigned OCCW = occ_width(LATENCY);

  if (LATENCY < MIN_LATENCY) begin : g_bad_latency
    $error("stallable_mult_pipe: LATENCY below minimum");
  end
  if (WIDTH < MIN_WIDTH) begin : g_bad_width
    $error("stallable_mult_pipe: WIDTH below minimum");
  end

  logic clr;
`ifdef STALLABLE_MULT_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  logic adv, accept, retire;
  assign adv    = !bus.stall && !clr;
  assign accept = bus.in_valid && adv;
  assign retire = bus.out_valid && adv;

  logic [WIDTH-1:0] a1, b1;
  logic             v1;
  logic [PW-1:0]    ax, bx, p2;
  logic             v2;

  // Extension choice is the only place SIGNED matters; low WIDTH bits are identical.
  always_comb begin
    ax = {{WIDTH{1'b0}}, a1};
    bx = {{WIDTH{1'b0}}, b1};
    if (SIGNED != 0) begin
      ax = {{WIDTH{a1[WIDTH-1]}}, a1};
      bx = {{WIDTH{b1[WIDTH-1]}}, b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a1 <= '0;
      b1 <= '0;
      v1 <= 1'b0;
      p2 <= '0;
      v2 <= 1'b0;
    end else begin
      if (adv) begin
        a1 <= bus.left;
        b1 <= bus.right;
        p2 <= ax * bx;
      end
      if (clr) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
      end else if (adv) begin
        v1 <= bus.in_valid;
        v2 <= v1;
      end
    end
  end

  logic [OW-1:0] q;
  logic          q_valid;

  if (LATENCY > 2) begin : g_chain
    stallable_delay_line #(
      .WIDTH (OW),
      .DEPTH (LATENCY - 2)
    ) u_delay (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (adv),
      .clr     (clr),
      .d       (p2[OW-1:0]),
      .d_valid (v2),
      .q       (q),
      .q_valid (q_valid)
    );
  end else begin : g_direct
    assign q       = p2[OW-1:0];
    assign q_valid = v2;
  end

  assign bus.out       = q;
  assign bus.out_valid = q_valid;

  logic [OCCW-1:0] occ_q, occ_d;
  logic            busy_q;

  always_comb begin
    occ_d = occ_q;
    if (clr)                     occ_d = '0;
    else if (accept && !retire)  occ_d = occ_q + OCCW'(1);
    else if (retire && !accept)  occ_d = occ_q - OCCW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      busy_q <= (occ_d != '0);
    end
  end

  assign bus.occupancy = occ_q;
  assign bus.busy      = busy_q;

endmodule
